// File: rtl/vram_rect_fill.sv
// ---------------------------------------------------------------------------
// vram_rect_fill
//
// Rectangle fill engine for a small LCD frame buffer. One command is accepted
// at a time and turned into a stream of single-pixel VRAM writes, one per
// clock, in raster order (x inner, y outer).
//
// Commands (cmd_op):
//   0 : fill rectangle with corners (x0,y0) and (x1,y1), any corner order
//   1 : clear screen, i.e. fill the whole frame with color
//   2 : single pixel at (x0,y0)
//   3 : reserved, rejected with an err pulse alongside done
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake, ready only while idle
//   cmd_op, x0..y1      command opcode and rectangle corners
//   color               pixel value {R,G,B}
//   vram_we             one pixel write per asserted cycle
//   vram_addr, vram_di  write address (H_RES*y + x) and data, held when idle
//   busy                command in progress (CLIP, FILL and DONE cycles)
//   done                one-cycle pulse when a command finishes
//   err                 one-cycle pulse with done for a reserved opcode
//
// Timing: first write two cycles after the accepting cycle; done arrives
// 2 + W*H cycles after acceptance, W*H being the clipped rectangle area.
// ---------------------------------------------------------------------------
module vram_rect_fill #(
    parameter int H_RES = 80,
    parameter int V_RES = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    input  logic [2:0]  color,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [2:0]  vram_di,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLIP = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_RECT  = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_PIXEL = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [7:0]  X_MAX    = 8'(H_RES - 1);
    localparam logic [7:0]  Y_MAX    = 8'(V_RES - 1);
    localparam logic [13:0] ROW_STEP = 14'(H_RES);

    logic [1:0]  state;
    logic        ready_q;     // low during reset, high from the first clock after
    logic        err_q;       // current command carried the reserved opcode

    // Command as latched on the handshake
    logic [1:0]  op_q;
    logic [7:0]  ax0, ax1, ay0, ay1;
    logic [2:0]  col_q;

    // Walk state for the normalised, clipped rectangle
    logic [7:0]  cx0, cx1, cy1;
    logic [7:0]  cur_x, cur_y;
    logic [13:0] row_base;

    // CLIP-stage combinational results
    logic [7:0]  nx0, nx1, ny0, ny1;
    logic        clip_empty;
    logic [13:0] clip_base;

    logic        handshake;
    logic        row_end;
    logic        last_px;
    logic [13:0] next_row_base;

    assign handshake     = cmd_valid & cmd_ready;
    assign row_end       = (cur_x == cx1);
    assign last_px       = row_end && (cur_y == cy1);
    assign next_row_base = row_base + ROW_STEP;

    // Status outputs are plain decodes of registered state, so the async
    // reset drops them immediately.
    assign cmd_ready = ready_q && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign vram_we   = (state == S_FILL);
    assign done      = (state == S_DONE);
    assign err       = (state == S_DONE) && err_q;

    // -----------------------------------------------------------------------
    // Normalisation and clipping of the latched command.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        nx0 = ax0;
        nx1 = ax1;
        ny0 = ay0;
        ny1 = ay1;
        case (op_q)
            OP_CLEAR: begin
                nx0 = 8'd0;
                nx1 = X_MAX;
                ny0 = 8'd0;
                ny1 = Y_MAX;
            end
            OP_PIXEL: begin
                nx1 = ax0;
                ny1 = ay0;
            end
            OP_RECT: begin
                if (ax0 > ax1) begin
                    nx0 = ax1;
                    nx1 = ax0;
                end
                if (ay0 > ay1) begin
                    ny0 = ay1;
                    ny1 = ay0;
                end
            end
            default: ;
        endcase

        // Only the far corner needs clamping: the near corner is either
        // on-screen (then it is <= the clamped far corner) or the whole
        // rectangle is off-screen and rejected below.
        if (nx1 > X_MAX) nx1 = X_MAX;
        if (ny1 > Y_MAX) ny1 = Y_MAX;

        clip_empty = (op_q == OP_RSVD) || (nx0 > X_MAX) || (ny0 > Y_MAX);

        // Constant multiply, evaluated once per command; the fill loop
        // itself only ever adds.
        clip_base = ROW_STEP * {6'd0, ny0};
    end

    // -----------------------------------------------------------------------
    // Control FSM and address walker.
    // -----------------------------------------------------------------------
    // NOTE: all state here is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            op_q      <= OP_RECT;
            ax0       <= 8'd0;
            ax1       <= 8'd0;
            ay0       <= 8'd0;
            ay1       <= 8'd0;
            col_q     <= 3'd0;
            cx0       <= 8'd0;
            cx1       <= 8'd0;
            cy1       <= 8'd0;
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
            row_base  <= 14'd0;
            vram_addr <= 14'd0;
            vram_di   <= 3'd0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        op_q  <= cmd_op;
                        ax0   <= x0;
                        ax1   <= x1;
                        ay0   <= y0;
                        ay1   <= y1;
                        col_q <= color;
                        state <= S_CLIP;
                    end
                end

                S_CLIP: begin
                    err_q <= (op_q == OP_RSVD);
                    if (clip_empty) begin
                        state <= S_DONE;
                    end else begin
                        cx0       <= nx0;
                        cx1       <= nx1;
                        cy1       <= ny1;
                        cur_x     <= nx0;
                        cur_y     <= ny0;
                        row_base  <= clip_base;
                        vram_addr <= clip_base + {6'd0, nx0};
                        vram_di   <= col_q;
                        state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (last_px) begin
                        // Address and data stay on the last pixel written.
                        state <= S_DONE;
                    end else if (row_end) begin
                        cur_x     <= cx0;
                        cur_y     <= cur_y + 8'd1;
                        row_base  <= next_row_base;
                        vram_addr <= next_row_base + {6'd0, cx0};
                    end else begin
                        cur_x     <= cur_x + 8'd1;
                        vram_addr <= vram_addr + 14'd1;
                    end
                end

                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_rect_fill.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vram_rect_fill
//
// Directed bench for vram_rect_fill with hand-computed expected write lists,
// write/done latencies and err behaviour. A negedge monitor collects every
// VRAM write (address, data, cycle) and every done/err pulse.
// ---------------------------------------------------------------------------
module tb_vram_rect_fill;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  x0, x1, y0, y1;
    logic [2:0]  color;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [2:0]  vram_di;
    logic        busy;
    logic        done;
    logic        err;

    vram_rect_fill #(.H_RES(80), .V_RES(160)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .color     (color),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_di   (vram_di),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // 10 MHz
    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the inactive edge
    int wa[$];
    int wd[$];
    int wc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int done_err = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (vram_we) begin
            wa.push_back(int'(vram_addr));
            wd.push_back(int'(vram_di));
            wc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = int'(err);
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int exp_q[$];

    // Offer one command and return the cycle number of the accepting cycle.
    task automatic issue(input logic [1:0] op, input int ix0, input int iy0,
                         input int ix1, input int iy1, input logic [2:0] col,
                         output int acc);
        int n;
        wa.delete(); wd.delete(); wc.delete();
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        x0        = 8'(ix0);
        y0        = 8'(iy0);
        x1        = 8'(ix1);
        y1        = 8'(iy1);
        color     = col;
        cmd_valid = 1'b1;
        acc       = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int max_cyc);
        int n;
        n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
    endtask

    // Compare captured writes against exp_q, plus latencies and err.
    task automatic check_cmd(input string tag, input int acc, input int col,
                             input int exp_done_lat, input int exp_err);
        check({tag, "_nwr"}, 32'(wa.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wa.size(); i++) begin
            check({tag, "_addr"}, 32'(wa[i]), 32'(exp_q[i]));
            check({tag, "_data"}, 32'(wd[i]), 32'(col));
        end
        if (exp_q.size() > 0 && wc.size() > 0)
            check({tag, "_first_lat"}, 32'(wc[0] - acc), 32'd2);
        check({tag, "_done_lat"}, 32'(done_cyc - acc), 32'(exp_done_lat));
        check({tag, "_err"}, 32'(done_err), 32'(exp_err));
    endtask

    int acc;
    int d0;
    int e0;
    int bad;
    int w0;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        x0 = 8'd0; x1 = 8'd0; y0 = 8'd0; y1 = 8'd0;
        color     = 3'd0;

        // Reset state
        #120;
        check("rst_ready",  32'(cmd_ready), 32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_we",     32'(vram_we),   32'd0);
        check("rst_addr",   32'(vram_addr), 32'd0);
        check("rst_di",     32'(vram_di),   32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_err",    32'(err),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release with no commands
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || busy !== 1'b0 || vram_we !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // Basic 3x2 rectangle
        d0 = done_cnt;
        issue(2'd0, 10, 5, 12, 6, 3'b100, acc);
        wait_done(d0, 100);
        exp_q = '{410, 411, 412, 490, 491, 492};
        check_cmd("rect", acc, 4, 8, 0);
        check("addr_held", 32'(vram_addr), 32'd492);
        check("di_held",   32'(vram_di),   32'd4);

        // Clipping at the bottom-right corner
        d0 = done_cnt;
        issue(2'd0, 78, 158, 200, 255, 3'b011, acc);
        wait_done(d0, 100);
        exp_q = '{12718, 12719, 12798, 12799};
        check_cmd("clip", acc, 3, 6, 0);

        // Swapped corners
        d0 = done_cnt;
        issue(2'd0, 5, 0, 3, 0, 3'b010, acc);
        wait_done(d0, 100);
        exp_q = '{3, 4, 5};
        check_cmd("swap", acc, 2, 5, 0);

        // Fully off-screen: zero writes, done 2 cycles after accept
        d0 = done_cnt;
        issue(2'd0, 90, 0, 95, 0, 3'b111, acc);
        wait_done(d0, 100);
        exp_q.delete();
        check_cmd("offscreen", acc, 7, 2, 0);

        // Single pixel at the last address
        d0 = done_cnt;
        issue(2'd2, 79, 159, 0, 0, 3'b101, acc);
        wait_done(d0, 100);
        exp_q = '{12799};
        check_cmd("pixel", acc, 5, 3, 0);

        // Reserved opcode
        d0 = done_cnt;
        e0 = err_cnt;
        issue(2'd3, 1, 1, 2, 2, 3'b001, acc);
        wait_done(d0, 100);
        exp_q.delete();
        check_cmd("rsvd", acc, 1, 2, 1);
        check("rsvd_err_pulses", 32'(err_cnt - e0), 32'd1);

        // Clear screen, with a reserved command offered mid-fill
        d0 = done_cnt;
        e0 = err_cnt;
        issue(2'd1, 3, 3, 4, 4, 3'b000, acc);
        repeat (500) @(negedge clk);
        check("ready_in_fill", 32'(cmd_ready), 32'd0);
        check("busy_in_fill",  32'(busy),      32'd1);
        cmd_op    = 2'd3;
        cmd_valid = 1'b1;
        color     = 3'b111;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(d0, 13000);
        check("clr_nwr", 32'(wa.size()), 32'd12800);
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] != 0) bad++;
        check("clr_contig", 32'(bad), 32'd0);
        if (wc.size() > 0) check("clr_first_lat", 32'(wc[0] - acc), 32'd2);
        check("clr_done_lat", 32'(done_cyc - acc), 32'd12802);
        check("clr_no_err",   32'(err_cnt - e0),   32'd0);
        repeat (3) @(negedge clk);
        check("clr_ignored_cmd", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of a clear
        d0 = done_cnt;
        issue(2'd1, 0, 0, 0, 0, 3'b110, acc);
        repeat (100) @(negedge clk);
        check("pre_rst_we", 32'(vram_we), 32'd1);
        #10 rst_n = 1'b0;
        #1;
        check("midrst_we",    32'(vram_we),   32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        check("midrst_addr",  32'(vram_addr), 32'd0);
        w0 = wa.size();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready_rel", 32'(cmd_ready), 32'd0);
        repeat (20) @(negedge clk);
        check("midrst_nwr",   32'(wa.size() - w0), 32'd0);
        check("midrst_nodone", 32'(done_cnt - d0), 32'd0);
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);

        // Engine still works after the abort
        d0 = done_cnt;
        issue(2'd0, 0, 1, 1, 1, 3'b001, acc);
        wait_done(d0, 100);
        exp_q = '{80, 81};
        check_cmd("post_rst", acc, 1, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
